// File: rtl/pwm_frame_loader.sv
// Byte-stream frame parser for the 4-group PWM datapath: assembles a checksummed
// 27-byte frame in shadow registers and publishes it atomically with a CTS strobe.
module pwm_frame_loader #(
    parameter int CTS_WIDTH  = 2,
    parameter int GAP_CYCLES = 20,
    parameter int TIMEOUT    = 255
) (
    input  logic        sys_clk,
    input  logic        sys_resetb,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [3:0]  cmd_o,
    output logic [47:0] data_o0,
    output logic [47:0] data_o1,
    output logic [47:0] data_o2,
    output logic [47:0] data_o3,
    output logic        cts_o,
    output logic        error_flag,
    output logic        frame_ok
);

    // state  | meaning
    // IDLE   | hunting for 0xA5 header, other bytes dropped
    // CMD    | waiting for CMD byte, seeds running XOR
    // DATA   | collecting 24 data bytes into shadow words
    // CHK    | checksum byte: commit on match, flag error otherwise
    // STROBE | cts_o held high for CTS_WIDTH cycles
    // GAP    | rx_ready low while the datapath latches the new words
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_CHK, S_STROBE, S_GAP} state_t;

    localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT - 1);
    localparam logic [15:0] CTS_LOAD = 16'(CTS_WIDTH - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        word_q, word_d;
    logic [2:0]        byte_q, byte_d;
    logic [7:0]        xor_q, xor_d;
    logic [3:0]        cmd_sh_q, cmd_sh_d;
    logic [3:0][47:0]  sh_q, sh_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [3:0][47:0]  data_q, data_d;
    logic              cts_q, cts_d;
    logic              err_q, err_d;
    logic              ok_q, ok_d;
    logic              rdy_q, rdy_d;
    logic              accept;

    assign accept = rx_valid && rdy_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        byte_d   = byte_q;
        xor_d    = xor_q;
        cmd_sh_d = cmd_sh_q;
        sh_d     = sh_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        cts_d    = cts_q;
        err_d    = err_q;
        ok_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && rx_data == 8'hA5) begin
                    state_d = S_CMD;
                    cnt_d   = TO_LOAD;
                end
            end
            S_CMD, S_DATA, S_CHK: begin
                if (accept) begin
                    cnt_d = TO_LOAD;
                    if (state_q == S_CMD) begin
                        cmd_sh_d = rx_data[3:0];
                        xor_d    = rx_data;
                        word_d   = 2'd0;
                        byte_d   = 3'd0;
                        state_d  = S_DATA;
                    end else if (state_q == S_DATA) begin
                        sh_d[word_q][{byte_q, 3'b000} +: 8] = rx_data;
                        xor_d = xor_q ^ rx_data;
                        if (byte_q == 3'd5) begin
                            byte_d = 3'd0;
                            word_d = word_q + 2'd1;
                            if (word_q == 2'd3) state_d = S_CHK;
                        end else begin
                            byte_d = byte_q + 3'd1;
                        end
                    end else if (rx_data == xor_q) begin
                        data_d  = sh_q;
                        cmd_d   = cmd_sh_q;
                        cts_d   = 1'b1;
                        ok_d    = 1'b1;
                        err_d   = 1'b0;
                        cnt_d   = CTS_LOAD;
                        state_d = S_STROBE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == 16'd0) begin
                    // inter-byte timeout: drop the partial frame
                    err_d   = 1'b1;
                    word_d  = 2'd0;
                    byte_d  = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 16'd0) begin
                    cts_d   = 1'b0;
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'd0) state_d = S_IDLE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
        rdy_d = (state_d == S_IDLE) || (state_d == S_CMD) ||
                (state_d == S_DATA) || (state_d == S_CHK);
    end

    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            byte_q   <= '0;
            xor_q    <= '0;
            cmd_sh_q <= '0;
            sh_q     <= '0;
            cmd_q    <= '0;
            data_q   <= '0;
            cts_q    <= 1'b0;
            err_q    <= 1'b0;
            ok_q     <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            byte_q   <= byte_d;
            xor_q    <= xor_d;
            cmd_sh_q <= cmd_sh_d;
            sh_q     <= sh_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            cts_q    <= cts_d;
            err_q    <= err_d;
            ok_q     <= ok_d;
            rdy_q    <= rdy_d;
        end
    end

    assign rx_ready   = rdy_q;
    assign cmd_o      = cmd_q;
    assign data_o0    = data_q[0];
    assign data_o1    = data_q[1];
    assign data_o2    = data_q[2];
    assign data_o3    = data_q[3];
    assign cts_o      = cts_q;
    assign error_flag = err_q;
    assign frame_ok   = ok_q;

endmodule

// File: tb/tb_pwm_frame_loader.sv
// Directed bench for pwm_frame_loader: good/bad frames, resync, timeout,
// back-to-back commit spacing and mid-frame reset.
module tb_pwm_frame_loader;

    logic        sys_clk = 1'b0;
    logic        sys_resetb = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [3:0]  cmd_o;
    logic [47:0] data_o0, data_o1, data_o2, data_o3;
    logic        cts_o, error_flag, frame_ok;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] dat [24];

    pwm_frame_loader dut (
        .sys_clk    (sys_clk),
        .sys_resetb (sys_resetb),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .cmd_o      (cmd_o),
        .data_o0    (data_o0),
        .data_o1    (data_o1),
        .data_o2    (data_o2),
        .data_o3    (data_o3),
        .cts_o      (cts_o),
        .error_flag (error_flag),
        .frame_ok   (frame_ok)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // drives the byte from a negedge and returns #1 after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge sys_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int k = 0; k < 24; k++) dat[k] = base + 8'(k);
    endtask

    task automatic send_body(input logic [7:0] cmd, input logic [7:0] chk);
        send_byte(cmd);
        for (int k = 0; k < 24; k++) send_byte(dat[k]);
        send_byte(chk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] chk);
        send_byte(8'hA5);
        send_body(cmd, chk);
    endtask

    initial begin
        int n;
        // reset
        #3 sys_resetb = 1'b0;
        #1;
        check("rst_cmd",   64'(cmd_o), 64'd0);
        check("rst_data0", 64'(data_o0), 64'd0);
        check("rst_cts",   64'(cts_o), 64'd0);
        check("rst_err",   64'(error_flag), 64'd0);
        check("rst_ok",    64'(frame_ok), 64'd0);
        check("rst_ready", 64'(rx_ready), 64'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_resetb = 1'b1;
        check("ready_before_edge", 64'(rx_ready), 64'd0);
        @(posedge sys_clk);
        #1;
        check("ready_after_edge", 64'(rx_ready), 64'd1);

        // good frame
        fill(8'h00);
        send_frame(8'h03, 8'h03);
        check("g1_cmd",   64'(cmd_o), 64'h3);
        check("g1_data0", 64'(data_o0), 64'h050403020100);
        check("g1_data1", 64'(data_o1), 64'h0b0a09080706);
        check("g1_data2", 64'(data_o2), 64'h11100f0e0d0c);
        check("g1_data3", 64'(data_o3), 64'h171615141312);
        check("g1_cts_c1", 64'(cts_o), 64'd1);
        check("g1_ok_c1",  64'(frame_ok), 64'd1);
        check("g1_err",    64'(error_flag), 64'd0);
        check("g1_ready",  64'(rx_ready), 64'd0);
        @(posedge sys_clk); #1;
        check("g1_cts_c2", 64'(cts_o), 64'd1);
        check("g1_ok_c2",  64'(frame_ok), 64'd0);
        @(posedge sys_clk); #1;
        check("g1_cts_c3", 64'(cts_o), 64'd0);

        // bad checksum: CMD 0x07 needs 0x07, send 0x04
        send_frame(8'h07, 8'h04);
        check("bad_err",   64'(error_flag), 64'd1);
        check("bad_cts",   64'(cts_o), 64'd0);
        check("bad_ok",    64'(frame_ok), 64'd0);
        check("bad_cmd",   64'(cmd_o), 64'h3);
        check("bad_data0", 64'(data_o0), 64'h050403020100);
        check("bad_ready", 64'(rx_ready), 64'd1);
        send_frame(8'h03, 8'h03);
        check("recov_err", 64'(error_flag), 64'd0);
        check("recov_ok",  64'(frame_ok), 64'd1);
        check("recov_cmd", 64'(cmd_o), 64'h3);

        // garbage before header, 0xA5 inside data, CMD high nibble ignored
        fill(8'h20);
        dat[7] = 8'hA5;
        send_byte(8'h11);
        send_byte(8'h22);
        send_frame(8'hFE, 8'h7C);
        check("gb_ok",    64'(frame_ok), 64'd1);
        check("gb_cmd",   64'(cmd_o), 64'hE);
        check("gb_data0", 64'(data_o0), 64'h252423222120);
        check("gb_data1", 64'(data_o1), 64'h2B2A2928A526);
        check("gb_data3", 64'(data_o3), 64'h373635343332);

        // stall after data byte 10
        fill(8'h00);
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int k = 0; k <= 10; k++) send_byte(dat[k]);
        rx_valid = 1'b0;
        repeat (254) @(posedge sys_clk);
        #1;
        check("to_err_early", 64'(error_flag), 64'd0);
        @(posedge sys_clk); #1;
        check("to_err",   64'(error_flag), 64'd1);
        check("to_ready", 64'(rx_ready), 64'd1);
        check("to_cmd",   64'(cmd_o), 64'hE);
        check("to_data1", 64'(data_o1), 64'h2B2A2928A526);
        send_byte(8'hA5);
        check("to_hdr_cmd", 64'(cmd_o), 64'hE);
        check("to_hdr_err", 64'(error_flag), 64'd1);
        send_body(8'h03, 8'h03);
        check("to_recov_err",   64'(error_flag), 64'd0);
        check("to_recov_cmd",   64'(cmd_o), 64'h3);
        check("to_recov_data0", 64'(data_o0), 64'h050403020100);

        // back-to-back: header held on the bus right after the commit
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        n = 0;
        @(negedge sys_clk);
        while (!rx_ready && n < 100) begin
            n++;
            @(negedge sys_clk);
        end
        check("b2b_gap", 64'(n), 64'd22);
        @(posedge sys_clk); #1;
        fill(8'h40);
        send_body(8'h09, 8'h09);
        check("b2b_ok",    64'(frame_ok), 64'd1);
        check("b2b_cmd",   64'(cmd_o), 64'h9);
        check("b2b_data3", 64'(data_o3), 64'h575655545352);

        // reset during data byte 12
        fill(8'h00);
        send_byte(8'hA5);
        send_byte(8'h02);
        for (int k = 0; k < 12; k++) send_byte(dat[k]);
        @(negedge sys_clk);
        rx_data = dat[12];
        #2 sys_resetb = 1'b0;
        #1;
        check("mr_cmd",   64'(cmd_o), 64'd0);
        check("mr_data0", 64'(data_o0), 64'd0);
        check("mr_data3", 64'(data_o3), 64'd0);
        check("mr_ready", 64'(rx_ready), 64'd0);
        check("mr_err",   64'(error_flag), 64'd0);
        rx_valid = 1'b0;
        @(negedge sys_clk);
        sys_resetb = 1'b1;
        send_frame(8'h03, 8'h03);
        check("mr_after_ok",    64'(frame_ok), 64'd1);
        check("mr_after_cmd",   64'(cmd_o), 64'h3);
        check("mr_after_data2", 64'(data_o2), 64'h11100f0e0d0c);
        rx_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
